wb_pipe: RTL and testbench

Parametrised write-back stage: MEM/WB pipeline register, N-way write-data select and register-file write-port driver in one block.
Adds what the plain write-back mux lacks: registered stage with valid, stall and flush; exactly-once write under stall; a halt state machine; forwarding taps.
Sits between the memory stage and the register file. Feeds the register-file write port and the decode/execute forwarding network.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_src_mux.sv | 23 ++
 rtl/wb_pipe.sv | 147 ++++++++++++++
 tb/tb_wb_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: source indices, FSM state
// type and default widths.
package wb_pkg;

  // Write-data source indices in the default four-source ordering
  localparam int SRC_PC2 = 32'sd0;
  localparam int SRC_MEM = 32'sd1;
  localparam int SRC_ALU = 32'sd2;
  localparam int SRC_CMP = 32'sd3;

  // Default widths
  localparam int DEF_DATA_W = 32'sd16;
  localparam int DEF_NSRC   = 32'sd4;
  localparam int DEF_REG_AW = 32'sd3;
  localparam int DEF_CNT_W  = 32'sd32;

  // Halt sequencing: RUN until a valid HALT reaches WB, one settling
  // cycle, then parked until reset
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_SEEN = 2'd1,
    HALTED    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_src_mux.sv
// NSRC-way write-data selector. Source k lives at bits [k*DATA_W +: DATA_W];
// a select value with no matching source falls back to source 0.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSRC   = DEF_NSRC,
  parameter int SEL_W  = $clog2(NSRC)
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [NSRC*DATA_W-1:0] src,
  output logic [DATA_W-1:0]      sel_data
);

  // Walk the sources; only an exact index match overrides the source-0 default
  always_comb begin
    sel_data = src[DATA_W-1:0];
    for (int k = 1; k < NSRC; k++) begin
      sel_data = (sel == SEL_W'(k)) ? src[k*DATA_W +: DATA_W] : sel_data;
    end
  end

endmodule

// File: rtl/wb_pipe.sv
// Write-back stage: MEM/WB pipeline register with valid/stall/flush,
// write-data select ahead of the register, exactly-once register-file
// write under stall, halt sequencing and forwarding taps.
// Optional build macro WB_RETIRE_CNT_EN adds a retired-instruction counter;
// without it retire_cnt reads constant 0.
module wb_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSRC   = DEF_NSRC,
  parameter int SEL_W  = $clog2(NSRC),
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [SEL_W-1:0]       RegSrc,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic                   in_RegWrt,
  input  logic [REG_AW-1:0]      in_WrtReg,
  input  logic                   in_halt,
  output logic [DATA_W-1:0]      WrtData,
  output logic [REG_AW-1:0]      WrtReg,
  output logic                   WrtEn,
  output logic                   fwd_valid,
  output logic [REG_AW-1:0]      fwd_reg,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   halted,
  output logic [CNT_W-1:0]       retire_cnt
);

  logic [DATA_W-1:0] sel_data_s;

  logic              wb_valid_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [REG_AW-1:0] wb_reg_r;
  logic              wb_regwrt_r;
  logic              wb_halt_r;
  logic              written_r;
  wb_state_t         state_r;

  logic              run_s;

  // Source selection happens in MEM so only the chosen word is registered
  wb_src_mux #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .sel      (RegSrc),
    .src      (src_data),
    .sel_data (sel_data_s)
  );

  assign run_s = (state_r == RUN);

  // Halt sequencing: a valid HALT in WB moves RUN -> HALT_SEEN -> HALTED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (wb_valid_r && wb_halt_r) begin
            state_r <= HALT_SEEN;
          end else begin
            state_r <= RUN;
          end
        end
        HALT_SEEN: state_r <= HALTED;
        HALTED:    state_r <= HALTED;
        default:   state_r <= RUN;
      endcase
    end
  end

  // MEM/WB register: halt freezes capture, flush squashes, stall holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_r  <= 1'b0;
      wb_data_r   <= {DATA_W{1'b0}};
      wb_reg_r    <= {REG_AW{1'b0}};
      wb_regwrt_r <= 1'b0;
      wb_halt_r   <= 1'b0;
    end else if (!run_s) begin
      wb_valid_r  <= 1'b0;
    end else if (flush) begin
      wb_valid_r  <= 1'b0;
    end else if (stall) begin
      wb_valid_r  <= wb_valid_r;
    end else begin
      wb_valid_r  <= in_valid;
      wb_data_r   <= sel_data_s;
      wb_reg_r    <= in_WrtReg;
      wb_regwrt_r <= in_RegWrt;
      wb_halt_r   <= in_halt;
    end
  end

  // Marks the held instruction as already written/retired so a multi-cycle
  // stall produces exactly one write; any instruction held by stall is marked,
  // which for writers coincides with the cycle WrtEn was high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_r <= 1'b0;
    end else if (!run_s) begin
      written_r <= written_r;
    end else if (flush) begin
      written_r <= 1'b0;
    end else if (stall) begin
      written_r <= written_r | wb_valid_r;
    end else begin
      written_r <= 1'b0;
    end
  end

  assign WrtData   = wb_data_r;
  assign WrtReg    = wb_reg_r;
  assign WrtEn     = wb_valid_r & wb_regwrt_r & ~wb_halt_r & ~written_r & run_s;
  assign fwd_valid = wb_valid_r & wb_regwrt_r & ~wb_halt_r;
  assign fwd_reg   = wb_reg_r;
  assign fwd_data  = wb_data_r;
  assign halted    = (state_r == HALTED);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_r;

  // Count each instruction once, on its first cycle in WB while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (wb_valid_r && !written_r && run_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
`else
  assign retire_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Directed bench for wb_pipe: default 4-source instance plus a 3-source
// instance sharing control inputs to exercise out-of-range select.
module tb_wb_pipe;
  import wb_pkg::*;

`ifdef WB_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  RegSrc;
  logic [63:0] src_data;
  logic        in_RegWrt;
  logic [2:0]  in_WrtReg;
  logic        in_halt;
  logic [15:0] WrtData;
  logic [2:0]  WrtReg;
  logic        WrtEn;
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;
  logic        halted;
  logic [31:0] retire_cnt;

  logic [1:0]  RegSrc3;
  logic [47:0] src_data3;
  logic [15:0] WrtData3;
  logic [2:0]  WrtReg3;
  logic        WrtEn3;
  logic        fwd_valid3;
  logic [2:0]  fwd_reg3;
  logic [15:0] fwd_data3;
  logic        halted3;
  logic [31:0] retire_cnt3;

  int total;
  int bad;

  wb_pipe #(.DATA_W(16), .NSRC(4), .SEL_W(2), .REG_AW(3), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .RegSrc(RegSrc), .src_data(src_data), .in_RegWrt(in_RegWrt),
    .in_WrtReg(in_WrtReg), .in_halt(in_halt), .WrtData(WrtData),
    .WrtReg(WrtReg), .WrtEn(WrtEn), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data), .halted(halted), .retire_cnt(retire_cnt)
  );

  wb_pipe #(.DATA_W(16), .NSRC(3), .SEL_W(2), .REG_AW(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .RegSrc(RegSrc3), .src_data(src_data3), .in_RegWrt(in_RegWrt),
    .in_WrtReg(in_WrtReg), .in_halt(in_halt), .WrtData(WrtData3),
    .WrtReg(WrtReg3), .WrtEn(WrtEn3), .fwd_valid(fwd_valid3), .fwd_reg(fwd_reg3),
    .fwd_data(fwd_data3), .halted(halted3), .retire_cnt(retire_cnt3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    RegSrc = 2'd0; in_RegWrt = 1'b0; in_WrtReg = 3'd0; in_halt = 1'b0;
    src_data  = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    RegSrc3   = 2'd0;
    src_data3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    #2;
    check_eq("rst_wrten", 32'(WrtEn), 32'd0);
    check_eq("rst_data", 32'(WrtData), 32'd0);
    check_eq("rst_reg", 32'(WrtReg), 32'd0);
    check_eq("rst_fwd", 32'(fwd_valid), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_cnt", retire_cnt, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Basic capture from each source, one cycle latency
    in_valid = 1'b1; in_RegWrt = 1'b1; in_WrtReg = 3'd5;
    RegSrc = 2'(SRC_ALU); RegSrc3 = 2'd3;
    tick();
    check_eq("alu_wrten", 32'(WrtEn), 32'd1);
    check_eq("alu_data", 32'(WrtData), 32'h1234);
    check_eq("alu_reg", 32'(WrtReg), 32'd5);
    check_eq("alu_fwd", 32'(fwd_valid), 32'd1);
    check_eq("alu_fwdreg", 32'(fwd_reg), 32'd5);
    check_eq("alu_fwddata", 32'(fwd_data), 32'h1234);
    check_eq("n3_oor_data", 32'(WrtData3), 32'hAAAA);
    check_eq("alu_cnt", retire_cnt, cnt_exp(0));
    RegSrc = 2'(SRC_PC2); in_WrtReg = 3'd1; RegSrc3 = 2'd2;
    tick();
    check_eq("pc2_data", 32'(WrtData), 32'h1111);
    check_eq("pc2_reg", 32'(WrtReg), 32'd1);
    check_eq("n3_src2_data", 32'(WrtData3), 32'hCCCC);
    check_eq("pc2_cnt", retire_cnt, cnt_exp(1));
    RegSrc = 2'(SRC_MEM); in_WrtReg = 3'd2;
    tick();
    check_eq("mem_data", 32'(WrtData), 32'h2222);
    check_eq("mem_wrten", 32'(WrtEn), 32'd1);
    RegSrc = 2'(SRC_CMP); in_WrtReg = 3'd4; in_RegWrt = 1'b0;
    tick();
    check_eq("cmp_data", 32'(WrtData), 32'h4444);
    check_eq("nowrt_wrten", 32'(WrtEn), 32'd0);
    check_eq("nowrt_fwd", 32'(fwd_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check_eq("idle_wrten", 32'(WrtEn), 32'd0);
    check_eq("grp1_cnt", retire_cnt, cnt_exp(4));

    // Write then three stalled cycles: one write, forwarding stays up
    in_valid = 1'b1; in_RegWrt = 1'b1; RegSrc = 2'(SRC_MEM); in_WrtReg = 3'd3;
    tick();
    check_eq("stl0_wrten", 32'(WrtEn), 32'd1);
    check_eq("stl0_fwd", 32'(fwd_valid), 32'd1);
    stall = 1'b1; RegSrc = 2'(SRC_ALU); in_WrtReg = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stl_wrten", 32'(WrtEn), 32'd0);
      check_eq("stl_fwd", 32'(fwd_valid), 32'd1);
      check_eq("stl_data", 32'(WrtData), 32'h2222);
      check_eq("stl_reg", 32'(WrtReg), 32'd3);
      check_eq("stl_cnt", retire_cnt, cnt_exp(5));
    end
    stall = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("stlx_fwd", 32'(fwd_valid), 32'd0);
    check_eq("stlx_wrten", 32'(WrtEn), 32'd0);
    check_eq("stlx_cnt", retire_cnt, cnt_exp(5));

    // Flush beats stall
    in_valid = 1'b1; RegSrc = 2'(SRC_PC2); in_WrtReg = 3'd1;
    tick();
    check_eq("fl0_wrten", 32'(WrtEn), 32'd1);
    check_eq("fl0_data", 32'(WrtData), 32'h1111);
    flush = 1'b1; stall = 1'b1;
    tick();
    check_eq("fl_wrten", 32'(WrtEn), 32'd0);
    check_eq("fl_fwd", 32'(fwd_valid), 32'd0);
    check_eq("fl_cnt", retire_cnt, cnt_exp(6));
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();

    // HALT: never writes, halted two cycles after capture, freezes stage
    in_valid = 1'b1; in_halt = 1'b1; in_RegWrt = 1'b1; in_WrtReg = 3'd7;
    RegSrc = 2'(SRC_ALU);
    tick();
    check_eq("h0_wrten", 32'(WrtEn), 32'd0);
    check_eq("h0_fwd", 32'(fwd_valid), 32'd0);
    check_eq("h0_halted", 32'(halted), 32'd0);
    in_halt = 1'b0; RegSrc = 2'(SRC_PC2); in_WrtReg = 3'd2;
    tick();
    check_eq("h1_wrten", 32'(WrtEn), 32'd0);
    check_eq("h1_halted", 32'(halted), 32'd0);
    check_eq("h1_cnt", retire_cnt, cnt_exp(7));
    tick();
    check_eq("h2_halted", 32'(halted), 32'd1);
    check_eq("h2_wrten", 32'(WrtEn), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("hx_halted", 32'(halted), 32'd1);
      check_eq("hx_wrten", 32'(WrtEn), 32'd0);
      check_eq("hx_cnt", retire_cnt, cnt_exp(7));
    end

    // Asynchronous reset out of HALTED, then normal operation resumes
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_halted", 32'(halted), 32'd0);
    check_eq("ar_cnt", retire_cnt, 32'd0);
    check_eq("ar_wrten", 32'(WrtEn), 32'd0);
    check_eq("ar_fwd", 32'(fwd_valid), 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_RegWrt = 1'b1; RegSrc = 2'(SRC_ALU); in_WrtReg = 3'd5;
    tick();
    check_eq("rs_wrten", 32'(WrtEn), 32'd1);
    check_eq("rs_data", 32'(WrtData), 32'h1234);
    check_eq("rs_reg", 32'(WrtReg), 32'd5);
    check_eq("rs_halted", 32'(halted), 32'd0);
    in_valid = 1'b0;
    tick();
    check_eq("rs_cnt", retire_cnt, cnt_exp(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
